// File: rtl/tx_fifo.sv
// Transmit FIFO: four 128-bit blocks in, read out as 32-bit words.
// Words leave low word first; a block retires after its fourth word.
module tx_fifo (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [127:0] tx_data_in,
  input  logic         tx_enq,
  input  logic         tx_deq_word,
  input  logic         flush,
  output logic [31:0]  tx_fifo_out,
  output logic [1:0]   word_idx,
  output logic         full,
  output logic         empty,
  output logic         tx_error
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    ERR
  } state_t;

  logic [127:0] mem [4];

  logic [1:0] head_ptr;
  logic [1:0] tail_ptr;
  logic       head_tog;
  logic       tail_tog;
  logic [1:0] idx;
  state_t     state;

  logic       enq_ok;
  logic       deq_ok;
  logic       bad_op;
  logic       retire;
  logic [2:0] head_nxt;
  logic [2:0] tail_nxt;

  assign full  = (tail_ptr == head_ptr) && (tail_tog != head_tog);
  assign empty = (tail_ptr == head_ptr) && (tail_tog == head_tog);

  assign enq_ok = tx_enq && !full;
  assign deq_ok = tx_deq_word && !empty;
  assign bad_op = (tx_enq && full) || (tx_deq_word && empty);
  assign retire = deq_ok && (idx == 2'd3);

  // The 3-bit increment flips the toggle bit on the slot 3 -> 0 wrap.
  assign head_nxt = {head_tog, head_ptr} + {2'd0, retire};
  assign tail_nxt = {tail_tog, tail_ptr} + {2'd0, enq_ok};

  assign word_idx = idx;
  assign tx_error = (state == ERR);

  always_comb begin
    tx_fifo_out = 32'h0;
    if (!empty) begin
      tx_fifo_out = mem[head_ptr][{idx, 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok && !flush) begin
      mem[tail_ptr] <= tx_data_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_ptr <= 2'd0;
      head_tog <= 1'b0;
      tail_ptr <= 2'd0;
      tail_tog <= 1'b0;
      idx      <= 2'd0;
      state    <= IDLE;
    end else if (flush) begin
      head_ptr <= 2'd0;
      head_tog <= 1'b0;
      tail_ptr <= 2'd0;
      tail_tog <= 1'b0;
      idx      <= 2'd0;
      state    <= IDLE;
    end else begin
      {head_tog, head_ptr} <= head_nxt;
      {tail_tog, tail_ptr} <= tail_nxt;
      if (deq_ok) begin
        idx <= retire ? 2'd0 : idx + 2'd1;
      end
      if (bad_op) begin
        state <= ERR;
      end else begin
        unique case (state)
          IDLE:    if (enq_ok) state <= STREAM;
          STREAM:  if (head_nxt == tail_nxt) state <= IDLE;
          ERR:     state <= ERR;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_fifo.sv
// Directed table-driven bench for tx_fifo.
// Vectors hold inputs for one edge and the outputs expected after it.
module tb_tx_fifo;

  logic         clk;
  logic         n_rst;
  logic [127:0] tx_data_in;
  logic         tx_enq;
  logic         tx_deq_word;
  logic         flush;
  logic [31:0]  tx_fifo_out;
  logic [1:0]   word_idx;
  logic         full;
  logic         empty;
  logic         tx_error;

  tx_fifo dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .tx_data_in  (tx_data_in),
    .tx_enq      (tx_enq),
    .tx_deq_word (tx_deq_word),
    .flush       (flush),
    .tx_fifo_out (tx_fifo_out),
    .word_idx    (word_idx),
    .full        (full),
    .empty       (empty),
    .tx_error    (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         enq;
    logic         deq;
    logic         fl;
    logic [127:0] data;
    logic [31:0]  out;
    logic [1:0]   idx;
    logic         full;
    logic         empty;
    logic         err;
  } vec_t;

  vec_t tv[$];
  int   total;
  int   bad;

  function automatic logic [127:0] blk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic add(input logic e, input logic d, input logic f,
                     input logic [127:0] data, input logic [31:0] o,
                     input logic [1:0] i, input logic fu,
                     input logic em, input logic er);
    vec_t v;
    v.enq = e; v.deq = d; v.fl = f; v.data = data;
    v.out = o; v.idx = i; v.full = fu; v.empty = em; v.err = er;
    tv.push_back(v);
  endtask

  // Read n blocks (bases first, first+0x100, ...) with a deq every cycle.
  // With strm set, the next block is enqueued while word 0 is read.
  task automatic add_drain(input logic [31:0] first, input int n,
                           input logic er, input logic full0,
                           input logic strm);
    int nb;
    int nk;
    logic e;
    logic [31:0] o;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 4; k++) begin
        nb = (k == 3) ? b + 1 : b;
        nk = (k == 3) ? 0 : k + 1;
        e  = strm && (k == 0) && (b < n - 1);
        o  = first + 32'(nb) * 32'h100 + 32'(nk);
        if (nb == n) begin
          add(e, 1'b1, 1'b0, blk(first + 32'(b + 1) * 32'h100),
              32'h0, 2'd0, 1'b0, 1'b1, er);
        end else begin
          add(e, 1'b1, 1'b0, blk(first + 32'(b + 1) * 32'h100),
              o, 2'(nk), full0 && (b == 0) && (k < 3), 1'b0, er);
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int n,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step%0d got=%h want=%h", nm, n, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int n, input vec_t v);
    chk({tag, "_out"}, n, tx_fifo_out, v.out);
    chk({tag, "_idx"}, n, {30'd0, word_idx}, {30'd0, v.idx});
    chk({tag, "_full"}, n, {31'd0, full}, {31'd0, v.full});
    chk({tag, "_empty"}, n, {31'd0, empty}, {31'd0, v.empty});
    chk({tag, "_err"}, n, {31'd0, tx_error}, {31'd0, v.err});
  endtask

  logic [127:0] a_blk;
  vec_t         ev;

  initial begin
    total = 0;
    bad   = 0;
    a_blk = 128'h44444444_33333333_22222222_11111111;

    // basic single block
    add(1, 0, 0, a_blk, 32'h11111111, 0, 0, 0, 0);
    add(0, 1, 0, '0, 32'h22222222, 1, 0, 0, 0);
    add(0, 1, 0, '0, 32'h33333333, 2, 0, 0, 0);
    add(0, 1, 0, '0, 32'h44444444, 3, 0, 0, 0);
    add(0, 1, 0, '0, 32'h0, 0, 0, 1, 0);
    // fill, overflow, drain
    add(1, 0, 0, blk(32'hB100), 32'hB100, 0, 0, 0, 0);
    add(1, 0, 0, blk(32'hB200), 32'hB100, 0, 0, 0, 0);
    add(1, 0, 0, blk(32'hB300), 32'hB100, 0, 0, 0, 0);
    add(1, 0, 0, blk(32'hB400), 32'hB100, 0, 1, 0, 0);
    add(1, 0, 0, blk(32'hB500), 32'hB100, 0, 1, 0, 1);
    add_drain(32'hB100, 4, 1, 1, 0);
    // underflow and flush
    add(0, 0, 1, '0, 32'h0, 0, 0, 1, 0);
    add(0, 1, 0, '0, 32'h0, 0, 0, 1, 1);
    add(0, 0, 1, '0, 32'h0, 0, 0, 1, 0);
    // enq while full on the retiring deq
    add(1, 0, 0, blk(32'hC100), 32'hC100, 0, 0, 0, 0);
    add(1, 0, 0, blk(32'hC200), 32'hC100, 0, 0, 0, 0);
    add(1, 0, 0, blk(32'hC300), 32'hC100, 0, 0, 0, 0);
    add(1, 0, 0, blk(32'hC400), 32'hC100, 0, 1, 0, 0);
    add(0, 1, 0, '0, 32'hC101, 1, 1, 0, 0);
    add(0, 1, 0, '0, 32'hC102, 2, 1, 0, 0);
    add(0, 1, 0, '0, 32'hC103, 3, 1, 0, 0);
    add(1, 1, 0, blk(32'hC500), 32'hC200, 0, 0, 0, 1);
    add_drain(32'hC200, 3, 1, 0, 0);
    add(0, 0, 1, '0, 32'h0, 0, 0, 1, 0);
    // flush wins over enq
    add(1, 0, 1, blk(32'hF100), 32'h0, 0, 0, 1, 0);
    // streaming across the slot wrap
    add(1, 0, 0, blk(32'hD100), 32'hD100, 0, 0, 0, 0);
    add_drain(32'hD100, 6, 0, 0, 1);
    // partial read before reset
    add(1, 0, 0, blk(32'hE100), 32'hE100, 0, 0, 0, 0);
    add(0, 1, 0, '0, 32'hE101, 1, 0, 0, 0);
    add(0, 1, 0, '0, 32'hE102, 2, 0, 0, 0);

    n_rst       = 1'b0;
    tx_data_in  = '0;
    tx_enq      = 1'b0;
    tx_deq_word = 1'b0;
    flush       = 1'b0;
    #12;
    ev = '{0, 0, 0, '0, 32'h0, 2'd0, 0, 1, 0};
    chk_all("reset", 0, ev);
    n_rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      tx_enq      = tv[i].enq;
      tx_deq_word = tv[i].deq;
      flush       = tv[i].fl;
      tx_data_in  = tv[i].data;
      @(posedge clk);
      #1;
      chk_all("vec", i, tv[i]);
    end
    tx_enq      = 1'b0;
    tx_deq_word = 1'b0;
    flush       = 1'b0;

    // asynchronous reset mid-block
    n_rst = 1'b0;
    #1;
    ev = '{0, 0, 0, '0, 32'h0, 2'd0, 0, 1, 0};
    chk_all("midrst", 0, ev);
    @(posedge clk);
    #1;
    chk_all("midrst", 1, ev);
    n_rst = 1'b1;
    tx_enq     = 1'b1;
    tx_data_in = blk(32'hE200);
    @(posedge clk);
    #1;
    tx_enq = 1'b0;
    ev = '{0, 0, 0, '0, 32'hE200, 2'd0, 0, 0, 0};
    chk_all("postrst", 0, ev);
    tx_deq_word = 1'b1;
    @(posedge clk);
    #1;
    tx_deq_word = 1'b0;
    ev = '{0, 0, 0, '0, 32'hE201, 2'd1, 0, 0, 0};
    chk_all("postrst", 1, ev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
